iiitb_bm_acc: RTL
=================

# iiitb_bm_acc

Signed product accumulator that sits directly downstream of the radix-2 Booth multiplier. It takes the multiplier's two's-complement products over a valid/ready handshake and sums a frame of N products with saturation. It then presents the frame sum, plus a sticky overflow flag, to the next stage over a second valid/ready handshake.

## Interface
- PW, 8, product width; matches the multiplier's P output.
- AW, 12, accumulator and result width; must be at least PW.
- N, 4, products per frame; must be at least 1.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous frame abort.
- in_valid  input  1  in_p holds a product.
- in_ready  output  1  block can accept a product.
- in_p  input  PW  signed product.
- out_valid  output  1  out_sum and out_sat are valid.
- out_ready  input  1  consumer takes the result.
- out_sum  output  AW  signed, saturated frame sum.
- out_sat  output  1  at least one add in the frame saturated.

## Operation
- Two states:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- in_ready and out_valid are decoded from the state only; there is no combinational path from in_valid or out_ready.
- Accept occurs when in_valid && in_ready at a rising edge. On accept:
  - acc <= sat(acc + sign-extend(in_p)), computed in AW+1 bits.
  - sat clamps the result to the range [-2^(AW-1), 2^(AW-1)-1].
  - If the clamp fires, the sticky bit is set.
  - cnt is incremented.
- On the accept where cnt == N-1:
  - The saturated sum is loaded into out_sum and the sticky result into out_sat.
  - State goes to HOLD.
- Cycles with in_valid=0 are bubbles: no count, no change to acc.
- HOLD with out_ready=1:
  - State returns to ACC.
  - acc, cnt and sticky are cleared.
  - out_sum and out_sat keep their last values; they are "don't care" while out_valid=0.
- HOLD with out_ready=0: all registers hold. in_p is not sampled.
- clear=1 (priority below reset only):
  - Next state is ACC.
  - acc, cnt, sticky, out_sum and out_sat are set to 0.
  - A same-cycle in_valid is discarded, and so is a result in HOLD.
- cnt runs 0..N-1 and never wraps past N-1; it resets to 0 on frame completion.
- Saturation in an intermediate add sets out_sat for the frame. Later adds continue from the clamped value.

## Timing
- While reset=0, and immediately on its assertion:
  - State is ACC, so in_ready=1.
  - out_valid=0, out_sum=0, out_sat=0.
  - acc=0, cnt=0.
  - No transfer is counted while reset is low.
- Latency: out_valid rises the cycle after the Nth accept.
- A result that is not taken is held indefinitely.
- Minimum frame period is N+1 cycles: N accepts plus one HOLD cycle with out_ready=1.
- The first accept of the next frame can occur in the cycle after the output handshake.
- Reset mid-frame or mid-HOLD discards everything asynchronously.

## Test plan
- N=4, AW=12: send products 0x1E (30), 0xFA (-6), 0x64 (100), 0x80 (-128) back-to-back with out_ready=1.
  - Required: out_valid pulses for one cycle, one cycle after the 4th accept.
  - Required: out_sum=0xFFC (-4), out_sat=0.
- Saturation, AW=9: send 0x7F, 0x7F, 0x7F, 0x80.
  - Required: running values 127, 254, 255 (clamped), 127.
  - Required: out_sum=127, out_sat=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after a result.
  - Required: out_valid=1 and out_sum unchanged; in_ready=0; products driven meanwhile are not accepted.
  - Then raise out_ready. Required: next cycle in_ready=1, and the following frame 1, 2, 3, 4 gives out_sum=10.
- Bubbles: interleave the frame 5, 5, 5, 5 with in_valid=0 gaps of 0-3 cycles.
  - Required: only 4 accepts counted; out_sum=20, exactly one result.
- Clear: accept 0x10 and 0x20, assert clear with in_valid=1 and in_p=0x30, then send 1, 2, 3, 4.
  - Required: out_sum=10, out_sat=0.
- Reset: pull reset low in HOLD.
  - Required: out_valid, out_sum and out_sat go to 0 without waiting for a clock edge; after release, in_ready=1 and a full new frame is required before the next out_valid.

Source files
------------

// File: rtl/iiitb_bm_acc.sv
`default_nettype none
// ============================================================================
// Module   : iiitb_bm_acc
// Purpose  : Saturating frame accumulator for signed Booth-multiplier products.
//            Sums N products per frame, then offers the clamped frame sum and
//            a sticky overflow flag to the next stage.
// Ports    : clk        rising-edge clock
//            reset      asynchronous, active-low reset
//            clear      synchronous frame abort (drops partial frame / result)
//            in_valid   in_p holds a product
//            in_ready   block accepts a product (state ACC)
//            in_p       PW-bit signed product
//            out_valid  out_sum / out_sat valid (state HOLD)
//            out_ready  consumer takes the result
//            out_sum    AW-bit signed saturated frame sum
//            out_sat    at least one add in the frame saturated
// Revision : 1.0 - initial release
// ============================================================================
module iiitb_bm_acc #(
    parameter int PW = 8,
    parameter int AW = 12,
    parameter int N  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_p,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic          out_sat
);

    // Counter is at least one bit wide so that N=1 still elaborates.
    localparam int              c_cw   = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(N - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    localparam logic [0:0] c_acc  = 1'b0;
    localparam logic [0:0] c_hold = 1'b1;

    localparam logic [AW-1:0] c_max = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] c_min = {1'b1, {(AW-1){1'b0}}};

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [AW-1:0]   r_acc;
    logic [c_cw-1:0] r_cnt;
    logic            r_sticky;
    logic [AW-1:0]   r_sum;
    logic            r_sat;

    logic            w_accept;
    logic            w_last;
    logic [AW:0]     w_ext;
    logic [AW:0]     w_raw;
    logic            w_ovf;
    logic [AW-1:0]   w_clamped;

    // Handshake outputs depend on state only.
    assign in_ready  = (r_state == c_acc);
    assign out_valid = (r_state == c_hold);
    assign out_sum   = r_sum;
    assign out_sat   = r_sat;

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_cnt == c_last);

    // One guard bit: the sum of two AW-bit signed values always fits in AW+1
    // bits, and an overflow shows up as the top two bits disagreeing.
    assign w_ext     = {{(AW+1-PW){in_p[PW-1]}}, in_p};
    assign w_raw     = {r_acc[AW-1], r_acc} + w_ext;
    assign w_ovf     = (w_raw[AW] != w_raw[AW-1]);
    assign w_clamped = w_ovf ? (w_raw[AW] ? c_min : c_max) : w_raw[AW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_acc;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = c_acc;
        end else begin
            case (r_state)
                c_acc:   if (w_accept && w_last) w_state_nxt = c_hold;
                c_hold:  if (out_ready)          w_state_nxt = c_acc;
                default: w_state_nxt = c_acc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_sum    <= '0;
            r_sat    <= 1'b0;
        end else if (clear) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_sum    <= '0;
            r_sat    <= 1'b0;
        end else if (w_accept) begin
            r_acc    <= w_clamped;
            r_sticky <= r_sticky | w_ovf;
            if (w_last) begin
                // Frame complete: publish the result and rewind the count.
                r_cnt <= '0;
                r_sum <= w_clamped;
                r_sat <= r_sticky | w_ovf;
            end else begin
                r_cnt <= r_cnt + c_one;
            end
        end else if (out_valid && out_ready) begin
            // Result taken: start the next frame from zero; the published
            // result registers keep their last value.
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end
    end

endmodule
`default_nettype wire
